// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
// Fetch FSM encodings, reset defaults and the IF/ID output slot bundle.
package mips_pkg;

    localparam logic [1:0] ST_BOOT    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } if_slot_t;

endpackage

// File: rtl/fetch_sequencer_pcplus4.sv
// Sequential-PC adder shared by the fetch unit.
// 32-bit add, wraps silently at the top of the address space.
module PCplus4 (
    input  logic [31:0] pc_i,
    output logic [31:0] pc4_o
);

    assign pc4_o = pc_i + 32'd4;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC, split-transaction imem handshake,
// and a single-entry output slot feeding the IF/ID register.
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_pc4_o
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4;
    logic        valid_q, valid_d;
    if_slot_t    slot_q, slot_d;
    logic        issue, load, consume;

    PCplus4 u_pcplus4 (
        .pc_i  (pc_q),
        .pc4_o (pc4)
    );

    // Request only when the slot is empty or is being drained this cycle.
    assign imem_req_o  = (state_q == ST_REQ) & (!valid_q | !stall_i);
    assign imem_addr_o = pc_q;

    assign issue   = imem_req_o & imem_gnt_i;
    assign load    = (state_q == ST_WAIT) & imem_rvalid_i & !redirect_i;
    assign consume = valid_q & !stall_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            ST_BOOT:    state_d = ST_REQ;
            ST_REQ:     if (issue) state_d = redirect_i ? ST_DISCARD : ST_WAIT;
            ST_WAIT: begin
                if (imem_rvalid_i)   state_d = ST_REQ;
                else if (redirect_i) state_d = ST_DISCARD;
            end
            ST_DISCARD: if (imem_rvalid_i) state_d = ST_REQ;
            default:    state_d = ST_BOOT;
        endcase
        if (redirect_i) pc_d = redirect_pc_i;
        else if (load)  pc_d = pc4;
    end

    always_comb begin
        slot_d = slot_q;
        if (redirect_i)   valid_d = 1'b0;
        else if (load)    valid_d = 1'b1;
        else if (consume) valid_d = 1'b0;
        else              valid_d = valid_q;
        // Keep the instruction output at NOP whenever the slot is empty.
        if (load)          slot_d = '{instr: imem_rdata_i, pc: pc_q, pc4: pc4};
        else if (!valid_d) slot_d.instr = NOP_INSTR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            slot_q  <= '{instr: NOP_INSTR, pc: 32'h0, pc4: 32'h0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            slot_q  <= slot_d;
        end
    end

    assign if_valid_o = valid_q;
    assign if_instr_o = slot_q.instr;
    assign if_pc_o    = slot_q.pc;
    assign if_pc4_o   = slot_q.pc4;

endmodule
